// File: rtl/olivia_pkg.sv
// Shared widths, fetch-entry layout and PC helpers for the instruction fetch slice.
package olivia_pkg;

   localparam int XLEN    = 64;
   localparam int INSTR_W = 32;
   localparam int PC_STEP = 4;

   typedef struct packed {
      logic [XLEN-1:0]    pc;
      logic [INSTR_W-1:0] instr;
   } fetch_entry_t;

   localparam int FETCH_ENTRY_W = $bits(fetch_entry_t);

   // Instructions are word aligned, so the low two address bits never survive.
   function automatic logic [XLEN-1:0] align_pc(input logic [XLEN-1:0] pc);
      return pc & ~XLEN'(3);
   endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Small FIFO with a combinational head read and a synchronous flush that wins over push/pop.
module fetch_fifo #(
   parameter  int WIDTH = 8,
   parameter  int DEPTH = 2,
   localparam int AW    = $clog2(DEPTH),
   localparam int CW    = $clog2(DEPTH) + 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             flush,
   input  logic             push,
   input  logic [WIDTH-1:0] push_data,
   input  logic             pop,
   output logic [WIDTH-1:0] head_data,
   output logic [CW-1:0]    count
);

   localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [AW-1:0]    wr_ptr_reg;
   logic [AW-1:0]    rd_ptr_reg;
   logic [CW-1:0]    count_reg;
   logic             do_push;
   logic             do_pop;

   // A full FIFO still takes a push when the head leaves in the same cycle.
   always_comb begin
      do_pop  = pop && (count_reg != '0);
      do_push = push && ((count_reg != FULL_COUNT) || do_pop);
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wr_ptr_reg <= '0;
         rd_ptr_reg <= '0;
         count_reg  <= '0;
      end else if (flush) begin
         wr_ptr_reg <= '0;
         rd_ptr_reg <= '0;
         count_reg  <= '0;
      end else begin
         wr_ptr_reg <= wr_ptr_reg + AW'(do_push);
         rd_ptr_reg <= rd_ptr_reg + AW'(do_pop);
         count_reg  <= count_reg + CW'(do_push) - CW'(do_pop);
      end
   end

   always_ff @(posedge clk) begin
      if (do_push && !flush) begin
         mem_q[wr_ptr_reg] <= push_data;
      end
   end

   assign head_data = mem_q[rd_ptr_reg];
   assign count     = count_reg;

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch: credit-limited request issue, in-order tag tracking, decode-side queue
// and redirect handling that discards responses to requests issued before the redirect.
module fetch_unit
   import olivia_pkg::*;
#(
   parameter logic [XLEN-1:0] RESET_PC = '0,
   parameter int              QDEPTH   = 2
) (
   input  logic               clk,
   input  logic               rst,
   output logic               imem_req_valid,
   output logic [XLEN-1:0]    imem_req_addr,
   input  logic               imem_req_ready,
   input  logic               imem_rsp_valid,
   input  logic [INSTR_W-1:0] imem_rsp_data,
   input  logic               redirect_valid,
   input  logic [XLEN-1:0]    redirect_pc,
   output logic               if_valid,
   input  logic               if_ready,
   output logic [XLEN-1:0]    if_pc,
   output logic [INSTR_W-1:0] if_instr
);

   localparam int            CW           = $clog2(QDEPTH) + 1;
   localparam logic [CW:0]   CREDIT_LIMIT = (CW+1)'(QDEPTH);

   logic [XLEN-1:0] pc_reg;
   logic [XLEN-1:0] pc_next;
   logic [CW-1:0]   discard_reg;
   logic [CW-1:0]   discard_next;

   logic [XLEN-1:0] tag_head;
   logic [CW-1:0]   tag_count;
   logic [CW-1:0]   q_count;
   fetch_entry_t    q_head;
   fetch_entry_t    q_push_entry;

   logic            req_fire;
   logic            rsp_keep;
   logic            if_fire;
   logic [CW-1:0]   outstanding;
   logic [CW:0]     in_use;

   // Every in-flight request is either still tagged or already doomed to be discarded.
   always_comb begin
      outstanding = tag_count + discard_reg;
      in_use      = {1'b0, outstanding} + {1'b0, q_count};
   end

   assign imem_req_valid = rst && !redirect_valid && (in_use < CREDIT_LIMIT);
   assign imem_req_addr  = pc_reg;
   assign req_fire       = imem_req_valid && imem_req_ready;
   assign rsp_keep       = imem_rsp_valid && !redirect_valid && (discard_reg == '0);

   assign if_valid = (q_count != '0);
   assign if_fire  = if_valid && if_ready;
   assign if_pc    = if_valid ? q_head.pc    : '0;
   assign if_instr = if_valid ? q_head.instr : '0;

   assign q_push_entry = '{pc: tag_head, instr: imem_rsp_data};

   always_comb begin
      pc_next = pc_reg;
      if (redirect_valid) begin
         pc_next = align_pc(redirect_pc);
      end else if (req_fire) begin
         pc_next = pc_reg + XLEN'(PC_STEP);
      end
   end

   // A response landing in the redirect cycle is dropped there, so it is not counted again.
   always_comb begin
      discard_next = discard_reg;
      if (redirect_valid) begin
         discard_next = outstanding - CW'(imem_rsp_valid);
      end else if ((discard_reg != '0) && imem_rsp_valid) begin
         discard_next = discard_reg - CW'(1);
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         pc_reg      <= RESET_PC;
         discard_reg <= '0;
      end else begin
         pc_reg      <= pc_next;
         discard_reg <= discard_next;
      end
   end

   fetch_fifo #(
      .WIDTH (XLEN),
      .DEPTH (QDEPTH)
   ) u_tag_fifo (
      .clk       (clk),
      .rst       (rst),
      .flush     (redirect_valid),
      .push      (req_fire),
      .push_data (pc_reg),
      .pop       (rsp_keep),
      .head_data (tag_head),
      .count     (tag_count)
   );

   fetch_fifo #(
      .WIDTH (FETCH_ENTRY_W),
      .DEPTH (QDEPTH)
   ) u_instr_queue (
      .clk       (clk),
      .rst       (rst),
      .flush     (redirect_valid),
      .push      (rsp_keep),
      .push_data (q_push_entry),
      .pop       (if_fire),
      .head_data (q_head),
      .count     (q_count)
   );

endmodule

// File: tb/tb_fetch_unit.sv
// Randomized bench for fetch_unit: memory model with in-order responses, queue-level reference
// model checked every cycle, plus directed scenarios with literal expectations.
module tb_fetch_unit;
   import olivia_pkg::*;

   localparam int QD = 2;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   // Main DUT (RESET_PC = 0, QDEPTH = 2)
   logic        rst;
   logic        imem_req_valid, imem_req_ready, imem_rsp_valid;
   logic [63:0] imem_req_addr;
   logic [31:0] imem_rsp_data;
   logic        redirect_valid;
   logic [63:0] redirect_pc;
   logic        if_valid, if_ready;
   logic [63:0] if_pc;
   logic [31:0] if_instr;

   // Wrap DUT (RESET_PC near 2^64, QDEPTH = 4)
   logic        rst2;
   logic        req_valid2, req_ready2, rsp_valid2;
   logic [63:0] req_addr2;
   logic [31:0] rsp_data2;
   logic        redirect2;
   logic [63:0] redirect_pc2;
   logic        if_valid2, if_ready2;
   logic [63:0] if_pc2;
   logic [31:0] if_instr2;

   fetch_unit #(.RESET_PC(64'h0), .QDEPTH(QD)) u_dut (
      .clk(clk), .rst(rst),
      .imem_req_valid(imem_req_valid), .imem_req_addr(imem_req_addr),
      .imem_req_ready(imem_req_ready), .imem_rsp_valid(imem_rsp_valid),
      .imem_rsp_data(imem_rsp_data), .redirect_valid(redirect_valid),
      .redirect_pc(redirect_pc), .if_valid(if_valid), .if_ready(if_ready),
      .if_pc(if_pc), .if_instr(if_instr)
   );

   fetch_unit #(.RESET_PC(64'hFFFF_FFFF_FFFF_FFF8), .QDEPTH(4)) u_wrap (
      .clk(clk), .rst(rst2),
      .imem_req_valid(req_valid2), .imem_req_addr(req_addr2),
      .imem_req_ready(req_ready2), .imem_rsp_valid(rsp_valid2),
      .imem_rsp_data(rsp_data2), .redirect_valid(redirect2),
      .redirect_pc(redirect_pc2), .if_valid(if_valid2), .if_ready(if_ready2),
      .if_pc(if_pc2), .if_instr(if_instr2)
   );

   int n_cmp = 0;
   int n_bad = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Memory contents: a fixed scramble of the address, so every word identifies its PC.
   function automatic logic [31:0] ins(input logic [63:0] a);
      return (a[31:0] * 32'h9E37_79B1) ^ a[63:32] ^ 32'h0000_0013;
   endfunction

   typedef struct {
      logic [63:0] addr;
      int          cyc;
      bit          stale;
   } mreq_t;

   mreq_t       mem_q[$];     // requests accepted by memory, not yet answered
   logic [63:0] iq_pc[$];     // PCs visible to decode, head first
   logic [63:0] model_pc;     // next address to fetch
   logic [63:0] seq_pc;       // next PC decode must see in program order
   int          cycle = 0;

   int          ready_mode, rsp_mode, ifr_mode;   // 0 random, 1 always, 2 never
   bit          do_redirect = 0;
   logic [63:0] redir_target = '0;
   bit          lit_pending = 0;
   logic [63:0] lit_next_pop = '0;
   bit          check_first_req = 0;
   logic [63:0] pop_log[$];
   int          pop_cyc[$];

   task automatic step();
      bit    rsp_ok, exp_v, exp_rv, pop;
      mreq_t r;
      @(negedge clk);
      cycle++;
      imem_req_ready = (ready_mode == 1) ? 1'b1 : (ready_mode == 2) ? 1'b0 : ($urandom_range(0, 3) != 0);
      if_ready       = (ifr_mode == 1)   ? 1'b1 : (ifr_mode == 2)   ? 1'b0 : ($urandom_range(0, 2) != 0);
      rsp_ok = (mem_q.size() > 0) && (mem_q[0].cyc < cycle);
      imem_rsp_valid = rsp_ok && ((rsp_mode == 1) || ((rsp_mode == 0) && ($urandom_range(0, 1) == 1)));
      imem_rsp_data  = imem_rsp_valid ? ins(mem_q[0].addr) : $urandom();
      redirect_valid = do_redirect;
      redirect_pc    = redir_target;
      do_redirect    = 0;
      #1;
      exp_v = (iq_pc.size() != 0);
      chk("if_valid", 64'(if_valid), 64'(exp_v));
      if (exp_v) begin
         chk("if_pc", if_pc, iq_pc[0]);
         chk("if_instr", 64'(if_instr), 64'(ins(iq_pc[0])));
      end
      exp_rv = !redirect_valid && ((mem_q.size() + iq_pc.size()) < QD);
      chk("imem_req_valid", 64'(imem_req_valid), 64'(exp_rv));
      if (exp_rv) chk("imem_req_addr", imem_req_addr, model_pc);
      if (check_first_req) begin
         chk("first_req_valid_after_reset", 64'(imem_req_valid), 64'd1);
         chk("first_req_addr_after_reset", imem_req_addr, 64'h0);
         check_first_req = 0;
      end
      // Apply what the coming edge does.
      pop = exp_v && if_ready;
      if (pop) begin
         chk("program_order_pc", if_pc, seq_pc);
         seq_pc = seq_pc + 64'd4;
         pop_log.push_back(if_pc);
         pop_cyc.push_back(cycle);
         if (lit_pending) begin
            chk("first_pc_after_redirect", if_pc, lit_next_pop);
            lit_pending = 0;
         end
         void'(iq_pc.pop_front());
      end
      if (imem_rsp_valid) begin
         r = mem_q.pop_front();
         if (!r.stale && !redirect_valid) iq_pc.push_back(r.addr);
      end
      if (redirect_valid) begin
         iq_pc.delete();
         foreach (mem_q[i]) mem_q[i].stale = 1;
         model_pc = redirect_pc & ~64'h3;
         seq_pc   = model_pc;
      end else if (exp_rv && imem_req_ready) begin
         mem_q.push_back('{addr: model_pc, cyc: cycle, stale: 1'b0});
         model_pc = model_pc + 64'd4;
      end
   endtask

   task automatic reset_model();
      mem_q.delete();
      iq_pc.delete();
      model_pc    = 64'h0;
      seq_pc      = 64'h0;
      lit_pending = 0;
   endtask

   task automatic pulse_reset();
      @(posedge clk);
      #2 rst = 1'b0;
      imem_rsp_valid = 1'b0;
      redirect_valid = 1'b0;
      #1;
      chk("async_reset_if_valid", 64'(if_valid), 64'd0);
      chk("async_reset_req_valid", 64'(imem_req_valid), 64'd0);
      chk("async_reset_if_pc", if_pc, 64'h0);
      reset_model();
      @(posedge clk);
      #2 rst = 1'b1;
      check_first_req = 1;
   endtask

   task automatic run_wrap();
      logic [63:0] wexp[6];
      logic [63:0] wpc[$];
      logic [31:0] wins[$];
      int          wcyc[$];
      bit          pend;
      logic [63:0] pend_addr;
      wexp = '{64'hFFFF_FFFF_FFFF_FFF8, 64'hFFFF_FFFF_FFFF_FFFC, 64'h0, 64'h4, 64'h8, 64'hC};
      pend = 0;
      pend_addr = '0;
      @(posedge clk);
      #2 rst2 = 1'b1;
      for (int k = 0; k < 12; k++) begin
         @(negedge clk);
         rsp_valid2 = pend;
         rsp_data2  = ins(pend_addr);
         #1;
         if (k == 0) chk("wrap_first_req_addr", req_addr2, 64'hFFFF_FFFF_FFFF_FFF8);
         if (if_valid2) begin
            wpc.push_back(if_pc2);
            wins.push_back(if_instr2);
            wcyc.push_back(k);
         end
         pend      = req_valid2;
         pend_addr = req_addr2;
      end
      @(negedge clk);
      req_ready2 = 1'b0;
      rsp_valid2 = 1'b0;
      chk("wrap_pop_count_ge6", 64'(wpc.size() >= 6), 64'd1);
      for (int i = 0; i < 6; i++) begin
         if (i < wpc.size()) begin
            chk("wrap_pc", wpc[i], wexp[i]);
            chk("wrap_instr", 64'(wins[i]), 64'(ins(wexp[i])));
            chk("wrap_one_per_cycle", 64'(wcyc[i]), 64'(2 + i));
         end
      end
   endtask

   initial begin
      int c0, guard;
      rst = 1'b0;  rst2 = 1'b0;
      imem_req_ready = 1'b0; imem_rsp_valid = 1'b0; imem_rsp_data = '0;
      redirect_valid = 1'b0; redirect_pc = '0; if_ready = 1'b0;
      req_ready2 = 1'b1; rsp_valid2 = 1'b0; rsp_data2 = '0;
      redirect2 = 1'b0; redirect_pc2 = '0; if_ready2 = 1'b1;
      ready_mode = 1; rsp_mode = 1; ifr_mode = 1;
      reset_model();

      repeat (2) @(posedge clk);
      #1;
      chk("reset_if_valid", 64'(if_valid), 64'd0);
      chk("reset_req_valid", 64'(imem_req_valid), 64'd0);
      chk("reset_if_instr", 64'(if_instr), 64'd0);

      run_wrap();

      // Fixed latency 1, decode always ready.
      @(posedge clk);
      #2 rst = 1'b1;
      check_first_req = 1;
      pop_log.delete(); pop_cyc.delete();
      c0 = cycle + 1;
      repeat (20) step();
      chk("lat1_pop_count_ge3", 64'(pop_log.size() >= 3), 64'd1);
      if (pop_log.size() >= 3) begin
         chk("lat1_pc0", pop_log[0], 64'h0);
         chk("lat1_pc1", pop_log[1], 64'h4);
         chk("lat1_pc2", pop_log[2], 64'h8);
         chk("req_to_if_valid_latency", 64'(pop_cyc[0] - c0), 64'd2);
      end

      // Decode stalls for 10 cycles.
      ifr_mode = 2;
      repeat (10) step();
      chk("stall_model_entries", 64'(iq_pc.size()), 64'(QD));
      chk("stall_if_valid", 64'(if_valid), 64'd1);
      chk("stall_req_valid", 64'(imem_req_valid), 64'd0);
      ifr_mode = 1;
      repeat (10) step();

      // Two requests outstanding, queue empty, then redirect to a misaligned target.
      rsp_mode = 2;
      guard = 0;
      while (!(mem_q.size() == 2 && iq_pc.size() == 0) && guard < 20) begin
         step();
         guard++;
      end
      chk("setup_two_outstanding", 64'(mem_q.size()), 64'd2);
      do_redirect  = 1;
      redir_target = 64'h1003;
      lit_pending  = 1;
      lit_next_pop = 64'h1000;
      step();
      rsp_mode = 1;
      repeat (10) step();
      chk("redirect_target_delivered", 64'(lit_pending), 64'd0);

      // Redirect coinciding with a response and a pop.
      ready_mode = 2;
      guard = 0;
      while ((mem_q.size() != 0 || iq_pc.size() != 0) && guard < 20) begin
         step();
         guard++;
      end
      ready_mode = 1; ifr_mode = 2;
      repeat (2) step();
      chk("setup_one_queued", 64'(iq_pc.size()), 64'd1);
      chk("setup_one_inflight", 64'(mem_q.size()), 64'd1);
      ifr_mode = 1;
      do_redirect  = 1;
      redir_target = 64'h2000;
      step();
      chk("redirect_pop_rsp_pop_seen", 64'(imem_rsp_valid && if_valid && if_ready), 64'd1);
      step();
      chk("queue_empty_after_redirect", 64'(if_valid), 64'd0);
      repeat (5) step();

      // Random traffic with occasional redirects and a reset pulse.
      ready_mode = 0; rsp_mode = 0; ifr_mode = 0;
      for (int n = 0; n < 3000; n++) begin
         if (n == 1500) pulse_reset();
         if ($urandom_range(0, 29) == 0) begin
            do_redirect = 1;
            if ($urandom_range(0, 3) == 0)
               redir_target = {32'hFFFF_FFFF, 32'hFFFF_FFE0 | 32'($urandom_range(0, 31))};
            else
               redir_target = {$urandom(), $urandom()};
         end
         step();
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
